// File: rtl/avg_pool_div_feeder.sv
// avg_pool_div_feeder: accumulates one window of unsigned feature samples
// (closed by WIN_LEN samples or in_last), issues a single start to the
// iterative divider with dividend = saturated sum and divisor = sample count,
// then presents the captured quotient/remainder on a valid/ready output.
//
// Optional feature macro: AVG_ROUND_NEAREST_EN
//   defined   -> dividend = min(sum + count/2, max), round-half-up average
//   undefined -> dividend = sum, truncating average
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and once raised out_valid and
// its data hold until the transfer completes.
//
// dbg_state exposes the FSM state (0=ACC, 1=ISSUE, 2=WAIT, 3=OUT).
module avg_pool_div_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int WIN_LEN    = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder,
    input  logic                  div_done,
    output logic [DATA_WIDTH-1:0] out_avg,
    output logic [DATA_WIDTH-1:0] out_rem,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] SUM_MAX = '1;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]  count;
    logic                  sat;
    logic                  wait_armed;

    logic                  in_fire;
    logic                  win_close;
    logic [DATA_WIDTH:0]   sum_ext;
    logic [DATA_WIDTH-1:0] sum_next;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  sat_acc;
    logic                  sat_close;
    logic [DATA_WIDTH-1:0] dividend_next;
`ifdef AVG_ROUND_NEAREST_EN
    logic [DATA_WIDTH:0]   rnd_ext;
`endif

    assign dbg_state = state;

    // in_ready is purely a function of state, so the accept decision uses state directly
    assign in_fire = in_valid && (state == ACC);

    // Saturating accumulate, window-close detection and the dividend to register on close
    always_comb begin
        sum_ext   = {1'b0, sum} + {1'b0, in_data};
        sum_next  = sum_ext[DATA_WIDTH] ? SUM_MAX : sum_ext[DATA_WIDTH-1:0];
        sat_acc   = sat | sum_ext[DATA_WIDTH];
        count_inc = count + CNT_WIDTH'(1);
        win_close = in_fire && (in_last || (count_inc == CNT_WIDTH'(WIN_LEN)));
`ifdef AVG_ROUND_NEAREST_EN
        // Adding half the divisor turns the truncating divide into round-half-up
        rnd_ext       = {1'b0, sum_next} + (DATA_WIDTH+1)'(count_inc >> 1);
        dividend_next = rnd_ext[DATA_WIDTH] ? SUM_MAX : rnd_ext[DATA_WIDTH-1:0];
        sat_close     = sat_acc | rnd_ext[DATA_WIDTH];
`else
        dividend_next = sum_next;
        sat_close     = sat_acc;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        div_start  = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (win_close) state_next = ISSUE;
            end
            ISSUE: begin
                div_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A done seen in the first WAIT cycle may belong to the previous operation
                if (wait_armed && div_done) state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    // Window accumulator, divider operands and captured result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum          <= '0;
            count        <= '0;
            sat          <= 1'b0;
            wait_armed   <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            out_avg      <= '0;
            out_rem      <= '0;
            out_sat      <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_fire) begin
                        sum   <= sum_next;
                        count <= count_inc;
                        sat   <= sat_acc;
                        if (win_close) begin
                            sat          <= sat_close;
                            div_dividend <= dividend_next;
                            div_divisor  <= DATA_WIDTH'(count_inc);
                        end
                    end
                end
                ISSUE: begin
                    wait_armed <= 1'b0;
                end
                WAIT: begin
                    wait_armed <= 1'b1;
                    if (wait_armed && div_done) begin
                        out_avg <= div_quotient;
                        out_rem <= div_remainder;
                        out_sat <= sat;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        sum   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_pool_div_feeder.sv
// tb_avg_pool_div_feeder: table-driven check of avg_pool_div_feeder with
// DATA_WIDTH=16, WIN_LEN=4 and a 6-cycle iterative divider model that can
// optionally hold div_done high across operations.
module tb_avg_pool_div_feeder;

    localparam int DW  = 16;
    localparam int LAT = 6;
`ifdef AVG_ROUND_NEAREST_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          in_ready;
    logic          div_start;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic [DW-1:0] div_quotient  = '0;
    logic [DW-1:0] div_remainder = '0;
    logic          div_done      = 1'b0;
    logic [DW-1:0] out_avg;
    logic [DW-1:0] out_rem;
    logic          out_sat;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    dbg_state;

    avg_pool_div_feeder #(
        .DATA_WIDTH(DW),
        .WIN_LEN   (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done),
        .out_avg      (out_avg),
        .out_rem      (out_rem),
        .out_sat      (out_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dbg_state    (dbg_state)
    );

    // ---------------- divider model ----------------
    // Not tied to the DUT reset, so a divide in flight during a reset still
    // produces its (late) done. With div_sticky set, done and the result stay
    // high until the cycle after the next start.
    logic          div_sticky = 1'b0;
    int            busy = 0;
    logic [DW-1:0] pend_q = '0;
    logic [DW-1:0] pend_r = '0;

    always @(posedge clk) begin
        if (div_start) begin
            pend_q <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
            pend_r <= (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
            busy   <= LAT;
            if (!div_sticky) div_done <= 1'b0;
        end else if (busy != 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
                div_done      <= 1'b1;
                div_quotient  <= pend_q;
                div_remainder <= pend_r;
            end else begin
                div_done <= 1'b0;
            end
        end else if (!div_sticky) begin
            div_done <= 1'b0;
        end
    end

    // Start-pulse monitor: counts pulses and captures the operands presented with each
    int            start_cnt = 0;
    logic [DW-1:0] cap_dvd = '0;
    logic [DW-1:0] cap_dvs = '0;
    always @(posedge clk) begin
        if (div_start) begin
            start_cnt <= start_cnt + 1;
            cap_dvd   <= div_dividend;
            cap_dvs   <= div_divisor;
        end
    end

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: timed out", name);
    endtask

    typedef struct {
        int               n;
        logic [3:0][15:0] d;
        logic             last;
        logic             sticky;
        logic             hold;
        logic             ordy_acc;
        logic [15:0]      e_dvd;
        logic [15:0]      e_dvs;
        logic [15:0]      e_avg;
        logic [15:0]      e_rem;
        logic             e_sat;
    } vec_t;

    function automatic vec_t mk(input int n,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d,
                                input logic last, input logic sticky,
                                input logic hold, input logic ordy,
                                input logic [15:0] dvd, input logic [15:0] dvs,
                                input logic [15:0] avg, input logic [15:0] rem,
                                input logic sat);
        vec_t v;
        v.n = n;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d;
        v.last = last; v.sticky = sticky; v.hold = hold; v.ordy_acc = ordy;
        v.e_dvd = dvd; v.e_dvs = dvs; v.e_avg = avg; v.e_rem = rem; v.e_sat = sat;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_sample(input logic [15:0] d, input logic last, input string tag);
        int waited;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) fail_now({tag, "_in_ready"});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base;
        int lat;
        base       = start_cnt;
        div_sticky = v.sticky;
        if (v.ordy_acc) begin
            out_ready = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            check({tag, "_ordy_acc"}, {dbg_state, out_valid, in_ready}, {2'd0, 1'b0, 1'b1});
        end
        for (int k = 0; k < v.n; k++) send_sample(v.d[k], v.last && (k == v.n - 1), tag);
        check({tag, "_busy_in_ready"}, in_ready, 1'b0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            fail_now({tag, "_out_valid"});
        end else begin
            check({tag, "_latency"}, lat, 8);
            check({tag, "_starts"}, start_cnt - base, 1);
            check({tag, "_dividend"}, cap_dvd, v.e_dvd);
            check({tag, "_divisor"}, cap_dvs, v.e_dvs);
            check({tag, "_dvd_hold"}, div_dividend, v.e_dvd);
            check({tag, "_avg"}, out_avg, v.e_avg);
            check({tag, "_rem"}, out_rem, v.e_rem);
            check({tag, "_sat"}, out_sat, v.e_sat);
        end
        if (v.hold) begin
            out_ready = 1'b0;
            in_data   = 16'd999;
            in_valid  = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check($sformatf("%s_hold%0d", tag, c), {out_valid, in_ready, out_avg, out_rem},
                      {1'b1, 1'b0, v.e_avg, v.e_rem});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_xfer"}, {out_valid, in_ready}, 2'b01);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[9];
    vec_t vr;

    initial begin
        int seen;

        vecs[0] = mk(4, 16'd10, 16'd20, 16'd30, 16'd41, 1'b0, 1'b0, 1'b0, 1'b0,
                     RND ? 16'd103 : 16'd101, 16'd4, 16'd25, RND ? 16'd3 : 16'd1, 1'b0);
        vecs[1] = mk(3, 16'd7, 16'd8, 16'd9, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0,
                     RND ? 16'd25 : 16'd24, 16'd3, 16'd8, RND ? 16'd1 : 16'd0, 1'b0);
        vecs[2] = mk(4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0,
                     16'd65535, 16'd4, 16'd16383, 16'd3, 1'b1);
        vecs[3] = mk(1, 16'd100, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1,
                     16'd100, 16'd1, 16'd100, 16'd0, 1'b0);
        vecs[4] = mk(4, 16'd1, 16'd2, 16'd3, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0,
                     RND ? 16'd12 : 16'd10, 16'd4, RND ? 16'd3 : 16'd2, RND ? 16'd0 : 16'd2, 1'b0);
        vecs[5] = mk(2, 16'h8000, 16'h8000, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                     16'd65535, 16'd2, 16'd32767, 16'd1, 1'b1);
        vecs[6] = mk(2, 16'd3, 16'd4, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                     RND ? 16'd8 : 16'd7, 16'd2, RND ? 16'd4 : 16'd3, RND ? 16'd0 : 16'd1, 1'b0);
        vecs[7] = mk(3, 16'd50, 16'd60, 16'd70, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                     RND ? 16'd181 : 16'd180, 16'd3, 16'd60, RND ? 16'd1 : 16'd0, 1'b0);
        vecs[8] = mk(4, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0,
                     RND ? 16'd6 : 16'd4, 16'd4, 16'd1, RND ? 16'd2 : 16'd0, 1'b0);
        vr = mk(2, 16'd5, 16'd5, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                RND ? 16'd11 : 16'd10, 16'd2, 16'd5, RND ? 16'd1 : 16'd0, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_state", dbg_state, 2'd0);
        check("rst_handshake", {in_ready, div_start, out_valid}, 3'b100);
        check("rst_div_ops", {div_dividend, div_divisor}, 32'd0);
        check("rst_out", {out_avg, out_rem, out_sat}, 33'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));
        div_sticky = 1'b0;

        // Reset while waiting on the divider
        send_sample(16'd1, 1'b0, "rw");
        send_sample(16'd1, 1'b1, "rw");
        repeat (3) begin @(posedge clk); #1; end
        check("rw_in_wait", dbg_state, 2'd2);
        reset = 1'b1;
        #1;
        check("rw_async_state", {dbg_state, in_ready, div_start, out_valid}, {2'd0, 3'b100});
        check("rw_async_ops", {div_dividend, div_divisor}, 32'd0);
        check("rw_async_out", {out_avg, out_rem, out_sat}, 33'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rw_no_late_valid", seen, 0);
        check("rw_in_ready", in_ready, 1'b1);
        run_vec(vr, "rw_next");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
